// File: rtl/char_flow_pkg.sv
// Shared types and constants for the character flow arbiter.
package char_flow_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CAP = 2'd1,
    GRANT_LOW = 2'd2
  } state_t;

  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] BANG   = 8'h21;
  localparam logic [7:0] CAP_LO = 8'h41;
  localparam logic [7:0] CAP_HI = 8'h5A;
  localparam logic [7:0] LOW_LO = 8'h61;
  localparam logic [7:0] LOW_HI = 8'h7A;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CAP  = 2'b10;
  localparam logic [1:0] GNT_LOW  = 2'b01;
endpackage

// File: rtl/char_flow_arbiter_chk.sv
// Combinational character classifier: word terminator and per-source letter class.
import char_flow_pkg::*;

module char_class_chk (
  input  logic [7:0] ch,
  input  logic       sel_cap,
  output logic       in_class,
  output logic       is_term
);
  logic is_upper, is_lower;

  assign is_term  = (ch == SPACE) || (ch == BANG);
  assign is_upper = (ch >= CAP_LO) && (ch <= CAP_HI);
  assign is_lower = (ch >= LOW_LO) && (ch <= LOW_HI);
  assign in_class = is_term || (sel_cap ? is_upper : is_lower);
endmodule

// File: rtl/char_flow_arbiter.sv
// Word-locked round-robin merge of an upper-case and a lower-case character stream.
// Optional build macro CHAR_FILTER_EN: swallow out-of-class characters and count them.
import char_flow_pkg::*;

module char_flow_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cap_data,
  input  logic       cap_valid,
  output logic       cap_ready,
  input  logic [7:0] low_data,
  input  logic       low_valid,
  output logic       low_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] grant,
  output logic       word_done,
  output logic [7:0] drop_cnt
);
  state_t     state, state_nxt;
  logic       last_cap;
  logic [7:0] beat_cnt;
  logic       sel_cap, granted;
  logic [7:0] src_data;
  logic       src_valid, src_ready;
  logic       in_class, is_term;
  logic       fwd, drop, xfer, last_beat, release_w;

  assign sel_cap   = (state == GRANT_CAP);
  assign granted   = (state != IDLE);
  assign src_data  = sel_cap ? cap_data : low_data;
  assign src_valid = granted && (sel_cap ? cap_valid : low_valid);

  char_class_chk u_chk (
    .ch       (src_data),
    .sel_cap  (sel_cap),
    .in_class (in_class),
    .is_term  (is_term)
  );

`ifdef CHAR_FILTER_EN
  assign fwd  = src_valid && in_class;
  assign drop = src_valid && !in_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      drop_cnt <= 8'h00;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
  end
`else
  logic unused_cls;
  assign unused_cls = in_class;
  assign fwd      = src_valid;
  assign drop     = 1'b0;
  assign drop_cnt = 8'h00;
`endif

  // Dropped characters are consumed regardless of downstream backpressure.
  assign src_ready = granted && (out_ready || drop);
  assign cap_ready = sel_cap && src_ready;
  assign low_ready = (state == GRANT_LOW) && src_ready;
  assign out_valid = fwd;
  assign out_data  = fwd ? src_data : SPACE;

  assign xfer      = fwd && out_ready;
  assign last_beat = (beat_cnt == 8'(MAX_BURST - 1));
  assign release_w = xfer && (is_term || last_beat);

  always_comb begin
    grant = GNT_NONE;
    if (state == GRANT_CAP)      grant = GNT_CAP;
    else if (state == GRANT_LOW) grant = GNT_LOW;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cap_valid && low_valid) state_nxt = last_cap ? GRANT_LOW : GRANT_CAP;
        else if (cap_valid)         state_nxt = GRANT_CAP;
        else if (low_valid)         state_nxt = GRANT_LOW;
      end
      GRANT_CAP, GRANT_LOW: begin
        if (release_w) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_cap  <= 1'b0;
      beat_cnt  <= 8'h00;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_done <= release_w;
      if (release_w) begin
        beat_cnt <= 8'h00;
        last_cap <= sel_cap;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 8'h01;
      end
    end
  end
endmodule
